// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge stage for a WIDTHxHEIGHT grayscale image.
// Reads one pixel per advance from a first-word-fall-through input FIFO and writes one
// edge pixel per output slot, in raster order. The output for centre pixel k is written
// on the cycle that consumes pixel k+WIDTH+1. After the last input pixel, a DRAIN phase
// emits the remaining WIDTH+1 outputs without reading. Border centres always output 0.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   in_dout/in_empty  input FIFO head pixel and empty flag; in_rd_en pops it
//   out_din/out_wr_en output pixel and push strobe; out_full stalls the stage
//   thresh_en         1 = binary output, 0 = clamped magnitude (latched per frame)
//   threshold         binary-mode threshold (latched per frame)
//   frame_done        one-cycle pulse after the last output pixel of a frame
module sobel_stream #(
    parameter int WIDTH       = 720,
    parameter int HEIGHT      = 540,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PIXEL_WIDTH-1:0] in_dout,
    input  logic                   in_empty,
    output logic                   in_rd_en,
    output logic [PIXEL_WIDTH-1:0] out_din,
    input  logic                   out_full,
    output logic                   out_wr_en,
    input  logic                   thresh_en,
    input  logic [PIXEL_WIDTH-1:0] threshold,
    output logic                   frame_done
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(NPIX);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int GW    = PIXEL_WIDTH + 3;   // holds +/-4*(2^PW-1) and |Gx|+|Gy|

    localparam logic [CNT_W-1:0]       LAST_PIX  = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0]       FIRST_OUT = CNT_W'(WIDTH + 1);
    localparam logic [COL_W-1:0]       LAST_COL  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]       LAST_ROW  = ROW_W'(HEIGHT - 1);
    localparam logic [PIXEL_WIDTH-1:0] PIX_MAX   = '1;

    typedef enum logic {RUN, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic [COL_W-1:0]       in_col_q, in_col_d;     // line-buffer address of the newest pixel
    logic [COL_W-1:0]       out_col_q, out_col_d;   // column of the output centre
    logic [ROW_W-1:0]       out_row_q, out_row_d;   // row of the output centre
    logic                   thr_en_q, thr_en_d;
    logic [PIXEL_WIDTH-1:0] thr_q, thr_d;
    logic                   frame_done_q, frame_done_d;

    // Window columns c-1 (index 0) and c (index 1); column c+1 is the incoming column.
    // Row index 0 is the oldest line (top), 2 the newest (bottom).
    logic [PIXEL_WIDTH-1:0] win_q [3][2];
    logic [PIXEL_WIDTH-1:0] win_d [3][2];

    // line_a holds the previous line, line_b the line before it, addressed by column.
    logic [PIXEL_WIDTH-1:0] line_a_mem [WIDTH];
    logic [PIXEL_WIDTH-1:0] line_b_mem [WIDTH];

    logic                   advance;
    logic [PIXEL_WIDTH-1:0] newest;
    logic [PIXEL_WIDTH-1:0] col_new [3];
    logic [GW-1:0]          gx, gy, abs_gx, abs_gy, mag;
    logic [PIXEL_WIDTH-1:0] pix_val;
    logic                   border;

    function automatic logic [GW-1:0] taps(input logic [PIXEL_WIDTH-1:0] a,
                                           input logic [PIXEL_WIDTH-1:0] b,
                                           input logic [PIXEL_WIDTH-1:0] c);
        return GW'(a) + (GW'(b) << 1) + GW'(c);
    endfunction

    // Datapath: window taps, gradients and the output pixel for the current centre.
    always_comb begin
        // Reset gates the strobes so nothing is popped or pushed while held in reset.
        advance    = reset && !out_full && (state_q == DRAIN || !in_empty);
        newest     = (state_q == RUN) ? in_dout : '0;
        col_new[0] = line_b_mem[in_col_q];
        col_new[1] = line_a_mem[in_col_q];
        col_new[2] = newest;

        // Differences are taken modulo 2^GW; the MSB is the two's-complement sign.
        gx = taps(col_new[0], col_new[1], col_new[2])
           - taps(win_q[0][0], win_q[1][0], win_q[2][0]);
        gy = taps(win_q[2][0], win_q[2][1], col_new[2])
           - taps(win_q[0][0], win_q[0][1], col_new[0]);
        abs_gx = gx[GW-1] ? GW'(0) - gx : gx;
        abs_gy = gy[GW-1] ? GW'(0) - gy : gy;
        mag    = abs_gx + abs_gy;

        if (thr_en_q) begin
            pix_val = (mag >= GW'(thr_q)) ? PIX_MAX : '0;
        end else begin
            pix_val = (mag > GW'(PIX_MAX)) ? PIX_MAX : mag[PIXEL_WIDTH-1:0];
        end

        border    = (out_row_q == '0) || (out_row_q == LAST_ROW)
                 || (out_col_q == '0) || (out_col_q == LAST_COL);
        in_rd_en  = advance && (state_q == RUN);
        out_wr_en = advance && (state_q == DRAIN || in_cnt_q >= FIRST_OUT);
        out_din   = (out_wr_en && !border) ? pix_val : '0;
    end

    // Next-state: counters, window shift, per-frame mode latch, frame end.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        in_col_d     = in_col_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        thr_en_d     = thr_en_q;
        thr_d        = thr_q;
        frame_done_d = 1'b0;
        win_d        = win_q;

        if (advance) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = col_new[r];
            end
            in_col_d = (in_col_q == LAST_COL) ? '0 : in_col_q + 1'b1;
        end

        if (in_rd_en) begin
            if (in_cnt_q == '0) begin
                thr_en_d = thresh_en;
                thr_d    = threshold;
            end
            if (in_cnt_q == LAST_PIX) begin
                in_cnt_d = '0;
                state_d  = DRAIN;
            end else begin
                in_cnt_d = in_cnt_q + 1'b1;
            end
        end

        if (out_wr_en) begin
            if (out_cnt_q == LAST_PIX) begin
                // Last write of the frame: realign everything for the next frame's pixel 0.
                state_d      = RUN;
                in_cnt_d     = '0;
                out_cnt_d    = '0;
                in_col_d     = '0;
                out_col_d    = '0;
                out_row_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q + 1'b1;
                if (out_col_q == LAST_COL) begin
                    out_col_d = '0;
                    out_row_d = out_row_q + 1'b1;
                end else begin
                    out_col_d = out_col_q + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            in_col_q     <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            thr_en_q     <= 1'b0;
            thr_q        <= '0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            in_col_q     <= in_col_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            thr_en_q     <= thr_en_d;
            thr_q        <= thr_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // NOTE: line buffers are not reset; every entry is rewritten before a non-border
    // centre reads it, so leaving them out of reset keeps them mappable to RAM.
    always_ff @(posedge clock) begin
        if (advance) begin
            line_a_mem[in_col_q] <= newest;
            line_b_mem[in_col_q] <= line_a_mem[in_col_q];
        end
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Directed testbench for sobel_stream: a 4x4 instance for the single-frame scenarios and
// a 5x3 instance for back-to-back frames under random stalls.
module tb_sobel_stream;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // 4x4 instance
    logic [7:0] in_dout4 = '0, out_din4, threshold4 = '0;
    logic       in_empty4 = 1'b1, out_full4 = 1'b0, thresh_en4 = 1'b0;
    logic       in_rd_en4, out_wr_en4, frame_done4;

    sobel_stream #(.WIDTH(4), .HEIGHT(4), .PIXEL_WIDTH(8)) u_dut4 (
        .clock(clock), .reset(reset),
        .in_dout(in_dout4), .in_empty(in_empty4), .in_rd_en(in_rd_en4),
        .out_din(out_din4), .out_full(out_full4), .out_wr_en(out_wr_en4),
        .thresh_en(thresh_en4), .threshold(threshold4), .frame_done(frame_done4)
    );

    // 5x3 instance
    logic [7:0] in_dout53 = '0, out_din53, threshold53 = '0;
    logic       in_empty53 = 1'b1, out_full53 = 1'b0, thresh_en53 = 1'b0;
    logic       in_rd_en53, out_wr_en53, frame_done53;

    sobel_stream #(.WIDTH(5), .HEIGHT(3), .PIXEL_WIDTH(8)) u_dut53 (
        .clock(clock), .reset(reset),
        .in_dout(in_dout53), .in_empty(in_empty53), .in_rd_en(in_rd_en53),
        .out_din(out_din53), .out_full(out_full53), .out_wr_en(out_wr_en53),
        .thresh_en(thresh_en53), .threshold(threshold53), .frame_done(frame_done53)
    );

    // Output monitor, sampled on the falling edge (inputs change just after rising edges).
    logic       mon_clr = 1'b0;
    logic [7:0] wr_q4[$], wr_q53[$];
    int rd_cnt4 = 0, fd_cnt4 = 0, wr_empty_cnt4 = 0, first_wr_rd4 = -1;
    int last_wr_cyc4 = 0, fd_cyc4 = 0;
    int rd_cnt53 = 0, fd_cnt53 = 0;

    always @(negedge clock) begin
        if (mon_clr) begin
            wr_q4.delete();
            wr_q53.delete();
            rd_cnt4 = 0; fd_cnt4 = 0; wr_empty_cnt4 = 0; first_wr_rd4 = -1;
            last_wr_cyc4 = 0; fd_cyc4 = 0;
            rd_cnt53 = 0; fd_cnt53 = 0;
        end else begin
            if (out_wr_en4) begin
                if (wr_q4.size() == 0) first_wr_rd4 = rd_cnt4;
                wr_q4.push_back(out_din4);
                if (in_empty4) wr_empty_cnt4++;
                last_wr_cyc4 = cyc_cnt;
            end
            if (in_rd_en4) rd_cnt4++;
            if (frame_done4) begin
                fd_cnt4++;
                fd_cyc4 = cyc_cnt;
            end
            if (out_wr_en53) wr_q53.push_back(out_din53);
            if (in_rd_en53) rd_cnt53++;
            if (frame_done53) fd_cnt53++;
        end
    end

    // Stimulus knobs for the 4x4 stream driver
    logic [7:0] img4 [16];
    logic [7:0] img53 [30];
    int         gap_e4 = 0, gap_f4 = 0;     // 1-in-N chance of in_empty / out_full (0 = never)
    bit         tail_busy4 = 1'b0;          // after the frame, offer non-empty dummy data
    int         thr_chg_idx = -1;
    logic [7:0] thr_chg_val = '0;

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clock);
        #1 mon_clr = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        in_empty4 = 1'b1; out_full4 = 1'b0; thresh_en4 = 1'b0; threshold4 = '0;
        in_empty53 = 1'b1; out_full53 = 1'b0; thresh_en53 = 1'b0; threshold53 = '0;
        gap_e4 = 0; gap_f4 = 0; tail_busy4 = 1'b0; thr_chg_idx = -1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        clear_mon();
    endtask

    // Streams img4 into the 4x4 instance until one frame_done is seen.
    task automatic stream4(output bit timed_out, output int early_rd);
        int idx = 0;
        int cyc = 0;
        int fd0 = fd_cnt4;
        timed_out = 1'b0;
        early_rd  = 0;
        while (fd_cnt4 == fd0) begin
            if (cyc >= 500) begin
                timed_out = 1'b1;
                break;
            end
            if (idx == thr_chg_idx) threshold4 = thr_chg_val;
            if (idx < 16) begin
                in_dout4  = img4[idx];
                in_empty4 = (gap_e4 != 0) && ($urandom_range(0, gap_e4 - 1) == 0);
            end else begin
                in_dout4  = 8'hFF;
                in_empty4 = !tail_busy4;
            end
            out_full4 = (gap_f4 != 0) && ($urandom_range(0, gap_f4 - 1) == 0);
            @(negedge clock);
            if (in_rd_en4 && idx >= 16 && !frame_done4) early_rd++;
            if (in_rd_en4) idx++;
            @(posedge clock);
            #1;
            cyc++;
        end
        in_empty4 = 1'b1;
        out_full4 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        in_empty4 = 1'b0; out_full4 = 1'b0; in_dout4 = 8'hFF;
        in_empty53 = 1'b0; out_full53 = 1'b0; in_dout53 = 8'hFF;
        @(posedge clock);
        #1;
        checks++; if (in_rd_en4 !== 1'b0) begin failures++; $display("FAIL reset_in_rd_en: got %b want 0", in_rd_en4); end
        checks++; if (out_wr_en4 !== 1'b0) begin failures++; $display("FAIL reset_out_wr_en: got %b want 0", out_wr_en4); end
        checks++; if (out_din4 !== 8'h00) begin failures++; $display("FAIL reset_out_din: got %h want 00", out_din4); end
        checks++; if (frame_done4 !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done4); end
        checks++; if (in_rd_en53 !== 1'b0) begin failures++; $display("FAIL reset_in_rd_en_5x3: got %b want 0", in_rd_en53); end
        apply_reset();
    endtask

    task automatic test_constant();
        bit to; int er;
        apply_reset();
        for (int i = 0; i < 16; i++) img4[i] = 8'h80;
        stream4(to, er);
        checks++; if (to) begin failures++; $display("FAIL const_timeout: frame_done not seen within budget"); end
        checks++; if (wr_q4.size() != 16) begin failures++; $display("FAIL const_count: got %0d writes want 16", wr_q4.size()); end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] got;
            got = (i < wr_q4.size()) ? wr_q4[i] : 8'hEE;
            checks++; if (got !== 8'h00) begin failures++; $display("FAIL const_pix[%0d]: got %h want 00", i, got); end
        end
        checks++; if (fd_cnt4 != 1) begin failures++; $display("FAIL const_fd_count: got %0d want 1", fd_cnt4); end
        checks++; if (fd_cyc4 != last_wr_cyc4 + 1) begin failures++; $display("FAIL const_fd_timing: fd cycle %0d, last write cycle %0d, want +1", fd_cyc4, last_wr_cyc4); end
        checks++; if (first_wr_rd4 != 5) begin failures++; $display("FAIL const_latency: first write after %0d reads want 5", first_wr_rd4); end
    endtask

    // Vertical step with random stalls on both FIFOs and next-frame data offered at the tail.
    task automatic test_backpressure();
        bit to; int er;
        apply_reset();
        for (int i = 0; i < 16; i++) img4[i] = ((i % 4) >= 2) ? 8'hFF : 8'h00;
        gap_e4 = 3; gap_f4 = 2; tail_busy4 = 1'b1;
        stream4(to, er);
        checks++; if (to) begin failures++; $display("FAIL vstep_timeout: frame_done not seen within budget"); end
        checks++; if (wr_q4.size() != 16) begin failures++; $display("FAIL vstep_count: got %0d writes want 16", wr_q4.size()); end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] got, exp;
            exp = (i == 5 || i == 6 || i == 9 || i == 10) ? 8'hFF : 8'h00;
            got = (i < wr_q4.size()) ? wr_q4[i] : 8'hEE;
            checks++; if (got !== exp) begin failures++; $display("FAIL vstep_pix[%0d]: got %h want %h", i, got, exp); end
        end
        checks++; if (er != 0) begin failures++; $display("FAIL vstep_read_in_drain: got %0d reads want 0", er); end
    endtask

    // Horizontal ramp, binary and magnitude mode, consecutive frames without reset.
    task automatic test_hramp();
        bit         to; int er;
        bit         cfg_en  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] cfg_thr [6] = '{8'd40, 8'd80, 8'd81, 8'd40, 8'd200, 8'd0};
        int         cfg_chg [6] = '{-1, -1, -1, 3, -1, -1};
        logic [7:0] cfg_exp [6] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h50};
        apply_reset();
        for (int i = 0; i < 16; i++) img4[i] = 8'((i / 4) * 10);
        thr_chg_val = 8'd200;
        for (int f = 0; f < 6; f++) begin
            thresh_en4  = cfg_en[f];
            threshold4  = cfg_thr[f];
            thr_chg_idx = cfg_chg[f];
            clear_mon();
            stream4(to, er);
            checks++; if (to || wr_q4.size() != 16) begin failures++; $display("FAIL hramp%0d_count: got %0d writes want 16 (timeout=%0d)", f, wr_q4.size(), to); end
            for (int i = 0; i < 16; i++) begin
                logic [7:0] got, exp;
                exp = (i == 5 || i == 6 || i == 9 || i == 10) ? cfg_exp[f] : 8'h00;
                got = (i < wr_q4.size()) ? wr_q4[i] : 8'hEE;
                checks++; if (got !== exp) begin failures++; $display("FAIL hramp%0d_pix[%0d]: got %h want %h", f, i, got, exp); end
            end
        end
        thr_chg_idx = -1;
    endtask

    // All 16 pixels, then the input FIFO stays empty: the last 5 outputs come from DRAIN.
    task automatic test_drain();
        bit to; int er;
        apply_reset();
        for (int i = 0; i < 16; i++) img4[i] = ((i % 4) >= 2) ? 8'hFF : 8'h00;
        gap_f4 = 2;
        stream4(to, er);
        checks++; if (to) begin failures++; $display("FAIL drain_timeout: frame_done not seen within budget"); end
        checks++; if (wr_empty_cnt4 != 5) begin failures++; $display("FAIL drain_writes: got %0d writes with input empty want 5", wr_empty_cnt4); end
        for (int i = 11; i < 16; i++) begin
            logic [7:0] got;
            got = (i < wr_q4.size()) ? wr_q4[i] : 8'hEE;
            checks++; if (got !== 8'h00) begin failures++; $display("FAIL drain_pix[%0d]: got %h want 00", i, got); end
        end
        checks++; if (er != 0) begin failures++; $display("FAIL drain_rd_en: got %0d reads want 0", er); end
        checks++; if (rd_cnt4 != 16) begin failures++; $display("FAIL drain_reads: got %0d reads want 16", rd_cnt4); end
    endtask

    // Reset after 7 pixels, then a clean frame with a single bright pixel at (1,1).
    task automatic test_reset_mid();
        bit to; int er;
        int idx = 0;
        int cyc = 0;
        apply_reset();
        for (int i = 0; i < 16; i++) img4[i] = (i == 5) ? 8'd100 : 8'd0;
        while (idx < 7 && cyc < 50) begin
            in_dout4  = img4[idx];
            in_empty4 = 1'b0;
            @(negedge clock);
            if (in_rd_en4) idx++;
            @(posedge clock);
            #1;
            cyc++;
        end
        in_dout4  = img4[7];
        in_empty4 = 1'b0;
        #1;
        checks++; if (out_wr_en4 !== 1'b1) begin failures++; $display("FAIL midrst_pre_wr: got %b want 1", out_wr_en4); end
        reset = 1'b0;
        #1;
        checks++; if (in_rd_en4 !== 1'b0) begin failures++; $display("FAIL midrst_in_rd_en: got %b want 0", in_rd_en4); end
        checks++; if (out_wr_en4 !== 1'b0) begin failures++; $display("FAIL midrst_out_wr_en: got %b want 0", out_wr_en4); end
        checks++; if (out_din4 !== 8'h00) begin failures++; $display("FAIL midrst_out_din: got %h want 00", out_din4); end
        in_empty4 = 1'b1;
        @(posedge clock);
        #1 reset = 1'b1;
        clear_mon();
        stream4(to, er);
        checks++; if (to || wr_q4.size() != 16) begin failures++; $display("FAIL midrst_count: got %0d writes want 16 (timeout=%0d)", wr_q4.size(), to); end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] got, exp;
            exp = (i == 6 || i == 9 || i == 10) ? 8'hC8 : 8'h00;
            got = (i < wr_q4.size()) ? wr_q4[i] : 8'hEE;
            checks++; if (got !== exp) begin failures++; $display("FAIL midrst_pix[%0d]: got %h want %h", i, got, exp); end
        end
    endtask

    // Two 5x3 frames back to back under 50% out_full and input gaps.
    task automatic test_back_to_back();
        int idx = 0;
        int cyc = 0;
        apply_reset();
        for (int i = 0; i < 15; i++) img53[i] = ((i % 5) >= 3) ? 8'hFF : 8'h00;
        for (int i = 0; i < 15; i++) img53[15 + i] = (i == 7) ? 8'd100 : 8'd0;
        while (fd_cnt53 < 2 && cyc < 2000) begin
            if (idx < 30) begin
                in_dout53  = img53[idx];
                in_empty53 = ($urandom_range(0, 3) == 0);
            end else begin
                in_dout53  = 8'h00;
                in_empty53 = 1'b1;
            end
            out_full53 = ($urandom_range(0, 1) == 0);
            @(negedge clock);
            if (in_rd_en53) idx++;
            @(posedge clock);
            #1;
            cyc++;
        end
        in_empty53 = 1'b1;
        out_full53 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (cyc >= 2000) begin failures++; $display("FAIL b2b_timeout: got %0d frame_done within budget want 2", fd_cnt53); end
        checks++; if (wr_q53.size() != 30) begin failures++; $display("FAIL b2b_count: got %0d writes want 30", wr_q53.size()); end
        checks++; if (fd_cnt53 != 2) begin failures++; $display("FAIL b2b_fd_count: got %0d want 2", fd_cnt53); end
        checks++; if (rd_cnt53 != 30) begin failures++; $display("FAIL b2b_reads: got %0d want 30", rd_cnt53); end
        for (int i = 0; i < 30; i++) begin
            logic [7:0] got, exp;
            exp = (i == 7 || i == 8) ? 8'hFF : (i == 21 || i == 23) ? 8'hC8 : 8'h00;
            got = (i < wr_q53.size()) ? wr_q53[i] : 8'hEE;
            checks++; if (got !== exp) begin failures++; $display("FAIL b2b_pix[%0d]: got %h want %h", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_backpressure();
        test_hramp();
        test_drain();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming 3x3 Sobel edge stage for the grayscale-to-edge pipeline. It sits between the grayscale FIFO and the output FIFO. Unlike the fixed single-frame Sobel stage, it is parametrised in image size and pixel width, uses internal line buffers, and zeroes border pixels. It drains the final row without further input and supports a runtime-selectable magnitude or binary-threshold output mode. It emits exactly one output pixel per input pixel, in raster order, and processes back-to-back frames.

## Interface
- WIDTH, 720, pixels per line (≥3)
- HEIGHT, 540, lines per frame (≥3)
- PIXEL_WIDTH, 8, bits per grayscale pixel
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- in_dout  input  PIXEL_WIDTH  input FIFO head pixel; valid when in_empty=0
- in_empty  input  1  input FIFO empty
- in_rd_en  output  1  pops input FIFO this cycle
- out_din  output  PIXEL_WIDTH  output pixel
- out_full  input  1  output FIFO full
- out_wr_en  output  1  pushes out_din this cycle
- thresh_en  input  1  1 = binary mode, 0 = magnitude mode; sampled per frame
- threshold  input  PIXEL_WIDTH  binary-mode threshold; sampled per frame
- frame_done  output  1  one-cycle pulse after last output pixel of a frame

## Operation
- States: RUN and DRAIN.
  - RUN consumes pixels.
  - DRAIN emits the last WIDTH+1 outputs with no input.
- Counters:
  - in_cnt, 0..WIDTH*HEIGHT-1: pixels consumed.
  - out_cnt, 0..WIDTH*HEIGHT-1: pixels written.
  - Track row/column of the output centre from out_cnt, or from separate row/col counters.
- Advance condition:
  - In RUN: in_empty=0 and out_full=0.
  - In DRAIN: out_full=0.
  - in_rd_en = advance && state==RUN.
- Window storage: two WIDTH-deep line buffers plus a 3x3 register window, shifted on each advance.
  - The newest pixel is in_dout in RUN and 0 in DRAIN.
- Output rule:
  - out_wr_en = advance && in_cnt ≥ WIDTH+1, counting the pixel consumed this cycle, or any advance in DRAIN.
  - The output for centre index k is written on the cycle that consumes pixel k+WIDTH+1.
- Gradients, centre p[r][c]:
  - Gx = (p[r-1][c+1] + 2p[r][c+1] + p[r+1][c+1]) − (same taps in column c-1).
  - Gy = bottom row − top row, with the same 1,2,1 weights.
  - Both are signed, PIXEL_WIDTH+3 bits.
- Magnitude: mag = |Gx| + |Gy|, unsigned, PIXEL_WIDTH+3 bits.
  - Magnitude mode: out_din = min(mag, 2^PIXEL_WIDTH−1).
  - Binary mode: out_din = all-ones if mag ≥ threshold, else 0.
- Border rule: centres in row 0, row HEIGHT-1, column 0 or column WIDTH-1 output 0 regardless of mode.
  - Window contents are never used across a line or frame boundary.
- thresh_en and threshold are latched on the advance that consumes in_cnt==0. The values stay fixed for the whole frame.
- Frame end:
  - On consuming pixel WIDTH*HEIGHT−1, go to DRAIN.
  - In DRAIN, emit WIDTH+1 zero pixels (all of them are border pixels).
  - On writing out_cnt==WIDTH*HEIGHT−1, clear the counters and return to RUN.
  - frame_done pulses on the following cycle.

## Timing
- Reset (reset=0, asynchronous):
  - in_rd_en=0, out_wr_en=0, out_din=0, frame_done=0.
  - State=RUN, all counters 0, latched mode = magnitude, latched threshold = 0.
  - Line buffer contents are don't-care.
- Mid-frame reset discards the partial frame. The next pixel after release is treated as pixel (0,0).
- in_rd_en, out_wr_en and out_din are combinational from the current state, counters, in_dout, in_empty and out_full. This assumes first-word-fall-through FIFOs.
- Throughput: one pixel per cycle when input is non-empty and output is not full.
- Latency: WIDTH+1 consumed pixels from a centre pixel to its output.
- Backpressure: out_full=1 stalls both read and write in the same cycle. No pixel is lost or duplicated.
  - The stall applies during fill too, with no output pending.
- in_empty=1 in RUN stalls the pipeline with no output. In DRAIN, in_empty is ignored.
- The next frame's pixels are not read until DRAIN completes.
- Arithmetic must close timing at one advance per cycle. Pipelining is not allowed, because it would change the specified latency.

## Test plan
- WIDTH=4, HEIGHT=4, PIXEL_WIDTH=8, constant 0x80 image, magnitude mode -> 16 outputs, all 0x00; frame_done pulses once, one cycle after the 16th write.
- 4x4 vertical step (columns 0,0,255,255), magnitude mode -> interior (1,1),(1,2),(2,1),(2,2) = 0xFF (Gx=1020 clamped); border = 0x00.
- 4x4 horizontal ramp, row r = 10r (all columns), thresh_en=1, threshold=40 -> interior mag = 80 -> 0xFF; rerun with threshold=81 -> interior 0x00; changing threshold mid-frame has no effect until next frame.
- Random out_full toggling (50%) and in_empty gaps over two back-to-back 5x3 frames -> output stream identical to a reference model; exactly 30 writes; 2 frame_done pulses.
- Feed all 16 pixels, then hold in_empty=1 -> final 5 outputs (out_cnt 11..15) written in DRAIN, all 0x00; in_rd_en stays 0 throughout DRAIN.
- Assert reset after 7 pixels of a frame -> all outputs 0 immediately (asynchronous); after release, a full 4x4 frame produces correct 16 outputs.
